// File: rtl/bool_eqv_pkg.sv
// Shared state encoding and sizing helpers for the boolean equivalence sweeper.
package bool_eqv_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DRIVE  = ST_DRIVE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } state_t;

  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

  // Wide enough for every pair mismatching on every vector.
  function automatic int cnt_width(input int n_in, input int n_pairs);
    return $clog2(vec_count(n_in) * n_pairs + 1);
  endfunction

endpackage

// File: rtl/bool_eqv_popcount.sv
// Combinational population count of a W-bit vector.
module bool_eqv_popcount #(
  parameter int W     = 4,
  parameter int OUT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     vec_i,
  output logic [OUT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + OUT_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/bool_eqv_sweeper.sv
// Exhaustive input sweeper comparing raw vs simplified outputs of a boolean block.
// Optional first-failure capture ports are enabled by defining BOOL_EQV_FIRST_FAIL_EN.
module bool_eqv_sweeper
  import bool_eqv_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int N_PAIRS = 4,
  parameter int SETTLE  = 1,
  localparam int CNT_W  = cnt_width(N_IN, N_PAIRS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_PAIRS-1:0] raw,
  input  logic [N_PAIRS-1:0] simp,
  output logic [N_IN-1:0]    abc,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_PAIRS-1:0] err_mask,
  output logic [CNT_W-1:0]   err_cnt
`ifdef BOOL_EQV_FIRST_FAIL_EN
  ,
  output logic               fail_valid,
  output logic [N_IN-1:0]    fail_vec,
  output logic [N_PAIRS-1:0] fail_mask
`endif
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PC_W  = $clog2(N_PAIRS + 1);
  localparam logic [N_IN-1:0]  ABC_LAST = '1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

  state_t             state_q, state_d;
  logic [N_IN-1:0]    abc_q, abc_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [N_PAIRS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_PAIRS-1:0] diff;
  logic [PC_W-1:0]    diff_pc;
  logic               start_acc;
  logic               sample_en;

  assign diff      = raw ^ simp;
  assign start_acc = start && (state_q == IDLE || state_q == DONE);
  assign sample_en = (state_q == SAMPLE);

  bool_eqv_popcount #(.W(N_PAIRS), .OUT_W(PC_W)) u_popcount (
    .vec_i (diff),
    .cnt_o (diff_pc)
  );

  always_comb begin
    state_d  = state_q;
    abc_d    = abc_q;
    settle_d = settle_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d  = DRIVE;
          abc_d    = '0;
          settle_d = '0;
          mask_d   = '0;
          cnt_d    = '0;
        end
      end
      DRIVE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SET_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        mask_d = mask_q | diff;
        cnt_d  = cnt_q + CNT_W'(diff_pc);
        if (abc_q == ABC_LAST) begin
          state_d = DONE;
        end else begin
          abc_d    = abc_q + 1'b1;
          settle_d = '0;
          state_d  = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      abc_q    <= '0;
      settle_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      abc_q    <= abc_d;
      settle_q <= settle_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
    end
  end

  assign abc      = abc_q;
  assign busy     = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done     = (state_q == DONE);
  assign pass     = done && (cnt_q == '0);
  assign err_mask = mask_q;
  assign err_cnt  = cnt_q;

`ifdef BOOL_EQV_FIRST_FAIL_EN
  logic               fvalid_q, fvalid_d;
  logic [N_IN-1:0]    fvec_q, fvec_d;
  logic [N_PAIRS-1:0] fmask_q, fmask_d;

  // Only the first mismatching vector of a run is latched.
  always_comb begin
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;
    fmask_d  = fmask_q;
    if (start_acc) begin
      fvalid_d = 1'b0;
      fvec_d   = '0;
      fmask_d  = '0;
    end else if (sample_en && (diff != '0) && !fvalid_q) begin
      fvalid_d = 1'b1;
      fvec_d   = abc_q;
      fmask_d  = diff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
      fmask_q  <= '0;
    end else begin
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
      fmask_q  <= fmask_d;
    end
  end

  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;
  assign fail_mask  = fmask_q;
`else
  logic unused_sample_en;
  assign unused_sample_en = sample_en;
`endif

endmodule

// File: tb/tb_bool_eqv_sweeper.sv
// Scoreboard bench for bool_eqv_sweeper: random truth tables, behavioural expected verdicts.
module tb_bool_eqv_sweeper;

  localparam int N_IN    = 3;
  localparam int N_PAIRS = 4;
  localparam int NV      = 8;
  localparam int CNT_W   = 6;
  localparam int SETTLE  = 1;

  typedef struct {
    int         cnt;
    logic [3:0] mask;
    int         pass;
    int         fvalid;
    int         fvec;
    logic [3:0] fmask;
    int         lat;
    time        t_start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] raw, simp;
  logic [2:0] abc;
  logic busy, done, pass;
  logic [3:0] err_mask;
  logic [CNT_W-1:0] err_cnt;
`ifdef BOOL_EQV_FIRST_FAIL_EN
  logic fail_valid;
  logic [2:0] fail_vec;
  logic [3:0] fail_mask;
  logic fail_valid3;
  logic [2:0] fail_vec3;
  logic [3:0] fail_mask3;
`endif

  logic start3 = 1'b0;
  logic [3:0] raw3, simp3;
  logic [2:0] abc3;
  logic busy3, done3, pass3;
  logic [3:0] mask3;
  logic [CNT_W-1:0] cnt3;

  logic [3:0] raw_tbl [NV];
  logic [3:0] flip_tbl [NV];

  int checks = 0;
  int errors = 0;
  int runs_done = 0;
  exp_t exp_q[$];
  logic [2:0] trace[$];
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    raw  = raw_tbl[abc];
    simp = raw_tbl[abc] ^ flip_tbl[abc];
  end
  assign raw3  = {1'b0, abc3};
  assign simp3 = {1'b0, abc3};

  bool_eqv_sweeper #(.N_IN(N_IN), .N_PAIRS(N_PAIRS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .raw(raw), .simp(simp),
    .abc(abc), .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .err_cnt(err_cnt)
`ifdef BOOL_EQV_FIRST_FAIL_EN
    , .fail_valid(fail_valid), .fail_vec(fail_vec), .fail_mask(fail_mask)
`endif
  );

  bool_eqv_sweeper #(.N_IN(N_IN), .N_PAIRS(N_PAIRS), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .raw(raw3), .simp(simp3),
    .abc(abc3), .busy(busy3), .done(done3), .pass(pass3),
    .err_mask(mask3), .err_cnt(cnt3)
`ifdef BOOL_EQV_FIRST_FAIL_EN
    , .fail_valid(fail_valid3), .fail_vec(fail_vec3), .fail_mask(fail_mask3)
`endif
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_run();
    exp_t e;
    int lat, bad, idx;
    chk("exp_pending", (exp_q.size() > 0) ? 1 : 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      lat = int'(($time - e.t_start - 5) / 10);
      chk("done_latency", lat, e.lat);
      chk("err_cnt", int'(err_cnt), e.cnt);
      chk("err_mask", int'(err_mask), int'(e.mask));
      chk("pass", int'(pass), e.pass);
      chk("busy_in_done", int'(busy), 0);
      chk("abc_in_done", int'(abc), NV - 1);
`ifdef BOOL_EQV_FIRST_FAIL_EN
      chk("fail_valid", int'(fail_valid), e.fvalid);
      chk("fail_vec", int'(fail_vec), e.fvec);
      chk("fail_mask", int'(fail_mask), int'(e.fmask));
`endif
      chk("abc_trace_len", trace.size(), NV * (SETTLE + 1));
      bad = 0;
      idx = 0;
      for (int v = 0; v < NV; v++) begin
        for (int s = 0; s <= SETTLE; s++) begin
          if (idx < trace.size() && int'(trace[idx]) != v) bad++;
          idx++;
        end
      end
      chk("abc_trace_order", bad, 0);
      $display("run %0d: err_cnt=%0d err_mask=%b pass=%0d latency=%0d", runs_done, err_cnt, err_mask, pass, lat);
    end
    trace.delete();
    runs_done++;
  endtask

  // Monitor: records the swept vectors and scores each completed run.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        trace.delete();
        done_prev = 1'b0;
      end else begin
        if (busy) trace.push_back(abc);
        if (done && !done_prev) check_run();
        done_prev = done;
      end
    end
  end

  task automatic load_tables(input int kind);
    for (int v = 0; v < NV; v++) begin
      raw_tbl[v] = 4'($urandom_range(0, 15));
      case (kind)
        0: flip_tbl[v] = 4'b0000;
        1: begin
          raw_tbl[v][1] = v[0];
          flip_tbl[v]   = {2'b00, v[0], 1'b0};
        end
        2: flip_tbl[v] = 4'b1111;
        default: flip_tbl[v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      endcase
    end
  endtask

  task automatic run_sweep(input int kind, input bit poke);
    exp_t e;
    int n0;
    load_tables(kind);
    e.cnt = 0; e.mask = 4'b0000; e.fvalid = 0; e.fvec = 0; e.fmask = 4'b0000;
    for (int v = 0; v < NV; v++) begin
      e.cnt += $countones(flip_tbl[v]);
      e.mask |= flip_tbl[v];
      if (e.fvalid == 0 && flip_tbl[v] != 4'b0000) begin
        e.fvalid = 1;
        e.fvec   = v;
        e.fmask  = flip_tbl[v];
      end
    end
    e.pass = (e.cnt == 0) ? 1 : 0;
    e.lat  = NV * (SETTLE + 1);
    n0 = runs_done;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    e.t_start = $time;
    exp_q.push_back(e);
    #1 start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_done_clr", int'(done), 0);
    chk("start_cnt_clr", int'(err_cnt), 0);
    chk("start_mask_clr", int'(err_mask), 0);
    chk("start_abc_zero", int'(abc), 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 100 && runs_done == n0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("run_completed", runs_done - n0, 1);
  endtask

  initial begin
    int w;
    int lat3, bad3;
    time t3;
    logic [2:0] q3[$];
    load_tables(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_abc", int'(abc), 0);
    chk("rst_cnt", int'(err_cnt), 0);
    chk("rst_mask", int'(err_mask), 0);
    #2 rst_n = 1'b1;

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);
    run_sweep(3, 1'b1);

    // Abort a run part-way through with an asynchronous reset.
    load_tables(2);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    w = 0;
    while (abc != 3'b100 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("abort_reach_vec4", int'(abc), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_abc", int'(abc), 0);
    chk("abort_cnt", int'(err_cnt), 0);
    chk("abort_mask", int'(err_mask), 0);
`ifdef BOOL_EQV_FIRST_FAIL_EN
    chk("abort_fail_valid", int'(fail_valid), 0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_sweep(0, 1'b0);
    for (int r = 0; r < 4; r++) run_sweep(int'($urandom_range(0, 3)), r[0]);

    // Longer settle time: each vector held SETTLE+1 = 4 cycles.
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    t3 = $time;
    #1 start3 = 1'b0;
    lat3 = -1;
    for (int i = 0; i < 200 && lat3 < 0; i++) begin
      @(negedge clk);
      if (done3) lat3 = int'(($time - t3 - 5) / 10);
      else if (busy3) q3.push_back(abc3);
    end
    chk("settle3_latency", lat3, 32);
    chk("settle3_trace_len", q3.size(), 32);
    bad3 = 0;
    for (int i = 0; i < q3.size(); i++) if (int'(q3[i]) != i / 4) bad3++;
    chk("settle3_trace_order", bad3, 0);
    chk("settle3_pass", int'(pass3), 1);
    chk("settle3_cnt", int'(cnt3), 0);
    $display("settle3 run: latency=%0d pass=%0d", lat3, pass3);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
